// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel/overlay generator.
interface vga_timing_gen_if #(
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 10
);
    logic          pix_en;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_en, hcount, vcount, hsync, vsync, active, line_start, frame_start
    );

    modport slave (
        input pix_en, hcount, vcount, hsync, vsync, active, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel-enable strobe on the board clock.
// Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/active by SYNC_DLY pixels.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10,
    parameter int unsigned SYNC_DLY = 2
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);
    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Delay depth collapses to zero when the feature is compiled out.
`ifdef VGA_SYNC_DELAY_EN
    localparam int unsigned DLY_N = SYNC_DLY;
`else
    localparam int unsigned DLY_N = SYNC_DLY * 0;
`endif

    logic [DW-1:0] div;
    logic          tick_c;
    logic          h_wrap_c;
    logic [HW-1:0] h_next_c;
    logic [VW-1:0] v_next_c;
    logic          hs_next_c;
    logic          vs_next_c;
    logic          act_next_c;

    logic [HW-1:0] hcount_q;
    logic [VW-1:0] vcount_q;
    logic          pix_en_q;
    logic          line_start_q;
    logic          frame_start_q;
    logic          hs_q;
    logic          vs_q;
    logic          act_q;

    assign tick_c = (div == DW'(CLK_DIV - 1));

    // Pixel divider: one tick every CLK_DIV board clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= tick_c ? '0 : div + DW'(1);
        end
    end

    // Next raster position and the decode of that position.
    always_comb begin
        h_wrap_c   = (hcount_q == HW'(H_TOTAL - 1));
        h_next_c   = h_wrap_c ? '0 : hcount_q + HW'(1);
        v_next_c   = vcount_q;
        if (h_wrap_c) begin
            v_next_c = (vcount_q == VW'(V_TOTAL - 1)) ? '0 : vcount_q + VW'(1);
        end
        hs_next_c  = (h_next_c >= HW'(HS_START)) && (h_next_c < HW'(HS_END));
        vs_next_c  = (v_next_c >= VW'(VS_START)) && (v_next_c < VW'(VS_END));
        act_next_c = (h_next_c < HW'(H_VIS)) && (v_next_c < VW'(V_VIS));
    end

    // Counters and decode move together so outputs always match the current position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q      <= HW'(H_TOTAL - 1);
            vcount_q      <= VW'(V_TOTAL - 1);
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            act_q         <= 1'b0;
        end else begin
            pix_en_q      <= tick_c;
            line_start_q  <= tick_c && (h_next_c == '0);
            frame_start_q <= tick_c && (h_next_c == '0) && (v_next_c == '0);
            if (tick_c) begin
                hcount_q <= h_next_c;
                vcount_q <= v_next_c;
                hs_q     <= hs_next_c ? HS_POL : ~HS_POL;
                vs_q     <= vs_next_c ? VS_POL : ~VS_POL;
                act_q    <= act_next_c;
            end
        end
    end

    assign bus.pix_en      = pix_en_q;
    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

    generate
        if (DLY_N > 0) begin : g_dly
            logic [DLY_N-1:0] hs_pipe;
            logic [DLY_N-1:0] vs_pipe;
            logic [DLY_N-1:0] act_pipe;

            // Shift register advancing one stage per pixel.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hs_pipe  <= {DLY_N{~HS_POL}};
                    vs_pipe  <= {DLY_N{~VS_POL}};
                    act_pipe <= '0;
                end else if (tick_c) begin
                    hs_pipe[0]  <= hs_q;
                    vs_pipe[0]  <= vs_q;
                    act_pipe[0] <= act_q;
                    for (int i = 1; i < int'(DLY_N); i++) begin
                        hs_pipe[i]  <= hs_pipe[i-1];
                        vs_pipe[i]  <= vs_pipe[i-1];
                        act_pipe[i] <= act_pipe[i-1];
                    end
                end
            end

            assign bus.hsync  = hs_pipe[DLY_N-1];
            assign bus.vsync  = vs_pipe[DLY_N-1];
            assign bus.active = act_pipe[DLY_N-1];
        end else begin : g_nodly
            assign bus.hsync  = hs_q;
            assign bus.vsync  = vs_q;
            assign bus.active = act_q;
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: arithmetic raster model compared every cycle on three configurations.
module tb_vga_timing_gen;
    typedef struct {
        bit pe;
        int h;
        int v;
        bit hs;
        bit vs;
        bit act;
        bit ls;
        bit fs;
    } exp_t;

    logic clk;
    logic rst0, rst1, rst2;
    int   n0, n1, n2;
    int   checks;
    int   errors;
    bit   cmp_en;
    exp_t e0, e1, e2;

    vga_timing_gen_if #(.HW(10), .VW(10)) bus0 ();
    vga_timing_gen_if #(.HW(3),  .VW(3))  bus1 ();
    vga_timing_gen_if #(.HW(5),  .VW(4))  bus2 ();

    vga_timing_gen dut0 (.clk(clk), .reset(rst0), .bus(bus0));

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .HW(3), .VW(3), .SYNC_DLY(2)
    ) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    vga_timing_gen #(
        .CLK_DIV(3), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b1), .HW(5), .VW(4), .SYNC_DLY(2)
    ) dut2 (.clk(clk), .reset(rst2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board clocks since reset release, per instance.
    always @(posedge clk) begin
        n0 <= rst0 ? 0 : n0 + 1;
        n1 <= rst1 ? 0 : n1 + 1;
        n2 <= rst2 ? 0 : n2 + 1;
    end

    // Position follows from the number of pixel ticks elapsed since reset.
    function automatic exp_t model(input int n, input bit r, input int cd,
                                   input int hv, input int hfp, input int hsw, input int hbp,
                                   input int vv, input int vfp, input int vsw, input int vbp,
                                   input bit hp, input bit vp);
        exp_t e;
        int ht, vt, t, pos;
        ht    = hv + hfp + hsw + hbp;
        vt    = vv + vfp + vsw + vbp;
        e.pe  = 1'b0;
        e.h   = ht - 1;
        e.v   = vt - 1;
        e.hs  = !hp;
        e.vs  = !vp;
        e.act = 1'b0;
        e.ls  = 1'b0;
        e.fs  = 1'b0;
        if (!r && n > 0) begin
            t = n / cd;
            if (t > 0) begin
                pos   = (t - 1) % (ht * vt);
                e.h   = pos % ht;
                e.v   = pos / ht;
                e.pe  = (n % cd) == 0;
                e.hs  = (e.h >= hv + hfp && e.h < hv + hfp + hsw) ? hp : !hp;
                e.vs  = (e.v >= vv + vfp && e.v < vv + vfp + vsw) ? vp : !vp;
                e.act = (e.h < hv) && (e.v < vv);
                e.ls  = e.pe && (e.h == 0);
                e.fs  = e.ls && (e.v == 0);
            end
        end
        return e;
    endfunction

    function automatic exp_t model0(input int n, input bit r);
        return model(n, r, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic exp_t model1(input int n, input bit r);
        return model(n, r, 1, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0);
    endfunction

    function automatic exp_t model2(input int n, input bit r);
        return model(n, r, 3, 16, 2, 3, 2, 8, 2, 2, 3, 1'b0, 1'b1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_bus(input string id, input exp_t e, input bit pe, input int h, input int v,
                           input bit hs, input bit vs, input bit act, input bit ls, input bit fs);
        chk({id, ".pix_en"}, int'(pe), int'(e.pe));
        chk({id, ".hcount"}, h, e.h);
        chk({id, ".vcount"}, v, e.v);
        chk({id, ".hsync"}, int'(hs), int'(e.hs));
        chk({id, ".vsync"}, int'(vs), int'(e.vs));
        chk({id, ".active"}, int'(act), int'(e.act));
        chk({id, ".line_start"}, int'(ls), int'(e.ls));
        chk({id, ".frame_start"}, int'(fs), int'(e.fs));
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            e0 = model0(n0, rst0);
            e1 = model1(n1, rst1);
            e2 = model2(n2, rst2);
            chk_bus("d0", e0, bus0.pix_en, int'(bus0.hcount), int'(bus0.vcount), bus0.hsync,
                    bus0.vsync, bus0.active, bus0.line_start, bus0.frame_start);
            chk_bus("d1", e1, bus1.pix_en, int'(bus1.hcount), int'(bus1.vcount), bus1.hsync,
                    bus1.vsync, bus1.active, bus1.line_start, bus1.frame_start);
            chk_bus("d2", e2, bus2.pix_en, int'(bus2.hcount), int'(bus2.vcount), bus2.hsync,
                    bus2.vsync, bus2.active, bus2.line_start, bus2.frame_start);
        end
    end

    initial begin
        int k, lowcnt, first_low, last_low, first_inact;
        int hs_hi, hs_bad, vs_lo, act_cnt, prev_h, prev_v, pe_cnt;
        exp_t m;

        checks = 0;
        errors = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        cmp_en = 1'b1;

        // Hand-computed pins on the model itself.
        m = model0(2, 1'b0);
        chk("model.d0_first_fs", int'(m.fs), 1);
        m = model0(2 * 657, 1'b0);
        chk("model.d0_h656", m.h, 656);
        chk("model.d0_hs_at_656", int'(m.hs), 0);
        m = model0(2 * 656, 1'b0);
        chk("model.d0_hs_at_655", int'(m.hs), 1);
        m = model1(42, 1'b0);
        chk("model.d1_last_h", m.h, 6);
        chk("model.d1_last_v", m.v, 5);
        m = model1(6, 1'b0);
        chk("model.d1_hs_at_5", int'(m.hs), 1);

        // Reset state.
        @(negedge clk);
        chk("d0.rst_hcount", int'(bus0.hcount), 799);
        chk("d0.rst_vcount", int'(bus0.vcount), 524);
        chk("d0.rst_hsync", int'(bus0.hsync), 1);
        chk("d0.rst_pix_en", int'(bus0.pix_en), 0);
        chk("d1.rst_hsync", int'(bus1.hsync), 0);
        chk("d2.rst_vsync", int'(bus2.vsync), 0);

        @(posedge clk);
        #2;
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;

        // First pixel tick after release lands on (0,0).
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus0.pix_en && k < 20);
        chk("d0.first_pe_clks", k - 1, 2);
        chk("d0.first_hcount", int'(bus0.hcount), 0);
        chk("d0.first_vcount", int'(bus0.vcount), 0);
        chk("d0.first_frame_start", int'(bus0.frame_start), 1);
        chk("d0.first_active", int'(bus0.active), 1);

        // One full line of dut0.
        k = 0; lowcnt = 0; first_low = -1; last_low = -1; first_inact = -1;
        do begin
            @(negedge clk);
            k++;
            if (bus0.pix_en) begin
                if (!bus0.hsync) begin
                    lowcnt++;
                    if (first_low < 0) first_low = int'(bus0.hcount);
                    last_low = int'(bus0.hcount);
                end
                if (!bus0.active && first_inact < 0) first_inact = int'(bus0.hcount);
            end
        end while (!bus0.line_start && k < 2000);
        chk("d0.line_period", k, 1600);
        chk("d0.hsync_width", lowcnt, 96);
        chk("d0.hsync_first", first_low, 656);
        chk("d0.hsync_last", last_low, 751);
        chk("d0.active_end", first_inact, 640);
        chk("d0.line1_vcount", int'(bus0.vcount), 1);

        // Mid-frame reset at (300,1).
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus0.pix_en && bus0.hcount == 10'd300) && k < 1000);
        chk("d0.reach_300", int'(bus0.hcount), 300);
        #1 rst0 = 1'b1;
        #1;
        chk("d0.midrst_hcount", int'(bus0.hcount), 799);
        chk("d0.midrst_vcount", int'(bus0.vcount), 524);
        chk("d0.midrst_hsync", int'(bus0.hsync), 1);
        chk("d0.midrst_vsync", int'(bus0.vsync), 1);
        chk("d0.midrst_active", int'(bus0.active), 0);
        chk("d0.midrst_pix_en", int'(bus0.pix_en), 0);
        repeat (2) @(posedge clk);
        #2 rst0 = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus0.pix_en && k < 20);
        chk("d0.restart_hcount", int'(bus0.hcount), 0);
        chk("d0.restart_vcount", int'(bus0.vcount), 0);
        chk("d0.restart_frame_start", int'(bus0.frame_start), 1);

        // Small configuration: one whole frame.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus1.frame_start && k < 100);
        k = 0; hs_hi = 0; hs_bad = 0; vs_lo = 0; act_cnt = 0; prev_h = -1; prev_v = -1;
        do begin
            prev_h = int'(bus1.hcount);
            prev_v = int'(bus1.vcount);
            @(negedge clk);
            k++;
            if (bus1.hsync) begin
                hs_hi++;
                if (bus1.hcount != 3'd5) hs_bad++;
            end
            if (!bus1.vsync) vs_lo++;
            if (bus1.active) act_cnt++;
        end while (!bus1.frame_start && k < 100);
        chk("d1.frame_period", k, 42);
        chk("d1.hsync_count", hs_hi, 6);
        chk("d1.hsync_off_col", hs_bad, 0);
        chk("d1.vsync_pixels", vs_lo, 7);
        chk("d1.active_pixels", act_cnt, 12);
        chk("d1.wrap_from_h", prev_h, 6);
        chk("d1.wrap_from_v", prev_v, 5);

        // Medium configuration with CLK_DIV=3: frame period and tick count.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus2.frame_start && k < 2000);
        k = 0; pe_cnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (bus2.pix_en) pe_cnt++;
        end while (!bus2.frame_start && k < 3000);
        chk("d2.frame_period", k, 1035);
        chk("d2.pix_per_frame", pe_cnt, 345);

        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Replaces the fixed 25 MHz divider plus separate horizontal/vertical counters with one block. Resolution, porches, sync widths, sync polarity and the pixel-clock divide ratio are all set by parameters. Runs on the board clock with a pixel-enable strobe instead of a derived clock. Feeds the pixel/overlay generator (including the keyboard-driven drawing logic) with counts, syncs, the active flag and frame/line strobes.

Parameters:
CLK_DIV, 2, board clocks per pixel (>=1); 2 gives 25 MHz from 50 MHz.
H_VIS, 640, visible pixels per line.
H_FP, 16, horizontal front porch (pixels).
H_SYNC, 96, hsync width (pixels).
H_BP, 48, horizontal back porch (pixels).
V_VIS, 480, visible lines.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vsync width (lines).
V_BP, 33, vertical back porch (lines).
HS_POL, 0, hsync active level (0 = active-low).
VS_POL, 0, vsync active level (0 = active-low).
HW, 10, hcount width; must hold H_TOTAL-1.
VW, 10, vcount width; must hold V_TOTAL-1.
SYNC_DLY, 2, sync/active delay in pixels (optional feature only).

Ports:
clk  in  1  board clock
reset  in  1  asynchronous, active-high
pix_en  out  1  one-clk pixel strobe
hcount  out  HW  current pixel column
vcount  out  VW  current line
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
active  out  1  1 inside visible area
line_start  out  1  1-clk strobe at hcount=0
frame_start  out  1  1-clk strobe at (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = 1 for exactly one clk when div == CLK_DIV-1.
  - CLK_DIV=1: pix_en is 1 every clk except while reset is asserted.
- Counters advance only on pix_en:
  - hcount == H_TOTAL-1 -> hcount wraps to 0, else hcount+1.
  - vcount increments only on the hcount wrap.
  - vcount == V_TOTAL-1 at that wrap -> vcount wraps to 0.
- Decode (all registered, updated in the same clk as the counters, so always consistent with the current hcount/vcount):
  - hsync asserted iff H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC.
  - vsync asserted iff V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC.
  - active = (hcount < H_VIS) && (vcount < V_VIS).
- Strobes:
  - line_start = pix_en && hcount == 0.
  - frame_start = line_start && vcount == 0.
  - Both are pure decode of registered state; no extra latency.
- Reset (async assert; release synchronised by the existing top-level reset logic):
  - div=0, hcount=H_TOTAL-1, vcount=V_TOTAL-1.
  - hsync/vsync at inactive level (!HS_POL / !VS_POL), active=0, pix_en=0, strobes 0.
  - The first pix_en after release moves the counters to (0,0), with frame_start=1 and active=1.
- Reset mid-frame: same values immediately; no partial-line recovery.
- Simultaneous H and V wrap on one pix_en: hcount->0 and vcount->0 in the same clk.
- Between pix_en strobes all outputs hold.
- Illegal parameters (any porch/sync of 0, HW/VW too small): unsupported, not checked in RTL.

Optional Feature:
Macro VGA_SYNC_DELAY_EN.
- Defined: hsync, vsync and active pass through a SYNC_DLY-stage shift register that advances only on pix_en. This aligns them with a pipelined pixel generator that is SYNC_DLY pixels deep.
  - Stage reset values are the inactive sync levels and 0 for active.
  - hcount, vcount, line_start and frame_start are NOT delayed.
  - SYNC_DLY=0 behaves as not defined.
- Not defined: SYNC_DLY is ignored; zero delay as above.

Test Plan:
- Defaults, CLK_DIV=2, reset released -> pix_en every 2nd clk; first pix_en gives hcount=0, vcount=0, frame_start=1, active=1.
- Run one line -> hsync low for exactly 96 pixels at hcount 656..751; active 0 from hcount 640; line period 1600 clks.
- Run one frame -> vsync low on lines 490..491; frame_start period 800*525*2 = 840000 clks; hcount 799 -> 0 and vcount 524 -> 0 in the same clk.
- Small parameters (H 4/1/1/1, V 3/1/1/1, CLK_DIV=1, HS_POL=1) -> hsync high only at hcount=5; H_TOTAL=7, V_TOTAL=6 wrap correctly.
- Assert reset at hcount=300, vcount=100 -> counters immediately 799/524, syncs inactive, active=0; restart at (0,0).
- VGA_SYNC_DELAY_EN, SYNC_DLY=2 -> hsync asserts 2 pix_en after hcount reaches 656; hcount itself is unchanged.
